sv_param_counter: RTL and testbench
===================================

// Module: sv_param_counter
// PURPOSE
//  Parametrised up/down counter: successor to the fixed 8-bit free-running counter.
//  Adds configurable width, modulo limit, prescaler, enable, direction control,
//  synchronous load/clear, wrap-or-saturate mode and terminal-count/wrap/saturate flags.
//  Used as the general timebase/event counter across the design.
// PARAMETERS
//  WIDTH     8           counter width in bits (>=2)
//  MAX_VAL   2**WIDTH-1  modulo limit; count range is 0..MAX_VAL (must be <= 2**WIDTH-1)
//  PRESCALE  1           enabled clock cycles per count step (>=1; 1 = step every enabled cycle)
//  SATURATE  0           0: wrap at the limits; 1: hold at the limits
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous active-high reset
//  en        in   1      count enable; gates the prescaler and stepping
//  up_dn     in   1      1 = count up, 0 = count down (dir_e)
//  clear     in   1      synchronous clear to 0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  load value; values > MAX_VAL are clamped to MAX_VAL
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal count (comb.): (up_dn && count==MAX_VAL) || (!up_dn && count==0)
//  wrap      out  1      registered 1-cycle pulse: count wrapped on the previous edge
//  sat       out  1      registered 1-cycle pulse: a step was blocked at a limit (SATURATE=1)
// BEHAVIOUR
//  - Reset (async, immediate, no clock needed): count=0, wrap=0, sat=0, prescaler=0.
//  - Per-edge priority: clear > load > step > hold.
//  - clear: count<=0 and prescaler<=0; wrap/sat<=0. Ignores en.
//  - load: count<=min(load_val,MAX_VAL) and prescaler<=0; wrap/sat<=0. Ignores en.
//  - Step tick = en && (prescaler==PRESCALE-1). While en=1, prescaler advances
//    0..PRESCALE-1 and then returns to 0. en=0 freezes the prescaler.
//    PRESCALE=1 gives a tick on every en cycle.
//  - On a tick, up: count<MAX_VAL -> count+1. At count==MAX_VAL:
//    SATURATE=0 -> 0 with wrap<=1; SATURATE=1 -> hold with sat<=1.
//  - On a tick, down: count>0 -> count-1. At count==0:
//    SATURATE=0 -> MAX_VAL with wrap<=1; SATURATE=1 -> hold with sat<=1.
//  - wrap/sat are high for exactly one cycle, coincident with the new count value.
//    Otherwise they are 0.
//  - Latency: count updates one clock after the tick cycle. tc follows count and
//    up_dn combinationally.
//  - up_dn change mid-prescale: the new direction applies at the next tick.
//    The prescaler is not reset.
//  - Arithmetic is WIDTH bits wide; MAX_VAL compare is exact; no intermediate overflow.
//    Elaboration error if MAX_VAL > 2**WIDTH-1 or PRESCALE < 1.
// STRUCTURE
//  - Package sv_counter_pkg: typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} dir_e;
//    function clamp_load(). The module checks its parameters at elaboration.
//  - Sub-module sv_counter_prescaler (PRESCALE): inputs clk, rst, en, restart;
//    output tick. Width is $clog2(PRESCALE), minimum 1. It is bypassed (tick=en)
//    when PRESCALE==1.
//  - The top holds the count register, next-state mux and flag registers.
// TESTING
//  1. rst=1 asserted mid-cycle with count=37 -> count=0, wrap=0, sat=0 before the next clk edge.
//  2. Defaults, en=1, up_dn=1 from 0: after 255 edges count=255 and tc=1.
//     Next edge: count=0, wrap=1 for one cycle.
//  3. Defaults, en=1, up_dn=0 from 0: next edge count=255 with a wrap pulse.
//     Then 254, then 253.
//  4. MAX_VAL=99: load=1, load_val=150, en=1 -> count=99 (clamped, no step).
//     Then clear=1 together with load=1 -> count=0.
//  5. PRESCALE=4, en=1 for 8 cycles from 0 -> count=2.
//     en=0 for 3 cycles, then en=1 for 1 cycle -> count stays 2 (prescaler frozen at 0, now 1).
//  6. SATURATE=1, MAX_VAL=99, count=99, up: count stays 99, sat pulses each tick, wrap=0.
//     Switch to up_dn=0 -> count 98.

Source files
------------

// File: rtl/sv_counter_pkg.sv
// Shared types and helpers for the parametrised counter.
// Direction encoding and load clamping.
package sv_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [31:0] clamp_load(
    input logic [31:0] v,
    input logic [31:0] maxv
  );
    return (v > maxv) ? maxv : v;
  endfunction

endpackage

// File: rtl/sv_counter_prescaler.sv
// Step-tick generator: one tick every PRESCALE enabled cycles.
// Collapses to a wire (tick = en) when PRESCALE is 1.
module sv_counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_ps;
    assign unused_ps = ^{clk, rst, restart};
    assign tick = en;
  end else begin : g_div
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ps <= '0;
      end else if (restart) begin
        ps <= '0;
      end else if (en) begin
        ps <= (ps == LAST) ? '0 : ps + 1'b1;
      end
    end

    assign tick = en && (ps == LAST);
  end

endmodule

// File: rtl/sv_param_counter.sv
// Parametrised up/down counter with prescaler, load/clear,
// wrap-or-saturate limits and terminal-count/wrap/sat flags.
module sv_param_counter
  import sv_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("sv_param_counter: WIDTH must be 2..32");
  end
  if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("sv_param_counter: MAX_VAL exceeds 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("sv_param_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  dir_e             dir;
  logic             tick;
  logic             restart;
  logic [WIDTH-1:0] load_cl;
  logic [WIDTH-1:0] cnt_n;
  logic             wrap_n;
  logic             sat_n;

  assign dir     = dir_e'(up_dn);
  assign restart = clear | load;
  assign load_cl = WIDTH'(clamp_load(32'(load_val), MAX_VAL));

  sv_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_ps (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .tick   (tick)
  );

  // clear beats load beats step; limit handling depends on SATURATE
  always_comb begin
    cnt_n  = count;
    wrap_n = 1'b0;
    sat_n  = 1'b0;
    if (clear) begin
      cnt_n = '0;
    end else if (load) begin
      cnt_n = load_cl;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (count == MAXV) begin
          if (SATURATE) begin
            sat_n = 1'b1;
          end else begin
            cnt_n  = '0;
            wrap_n = 1'b1;
          end
        end else begin
          cnt_n = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          if (SATURATE) begin
            sat_n = 1'b1;
          end else begin
            cnt_n  = MAXV;
            wrap_n = 1'b1;
          end
        end else begin
          cnt_n = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= cnt_n;
      wrap  <= wrap_n;
      sat   <= sat_n;
    end
  end

  assign tc = (up_dn && (count == MAXV)) ||
              (!up_dn && (count == '0));

endmodule

// File: tb/tb_sv_param_counter.sv
// Bench for sv_param_counter: four configurations share stimulus,
// an arithmetic model checks every cycle, literals pin key points.
module tb_sv_param_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] cnt [4];
  logic       tcv [4];
  logic       wr  [4];
  logic       st  [4];

  int total = 0;
  int bad   = 0;

  // configs: defaults / MAX 99 / PRESCALE 4 / saturating MAX 99
  int cmax [4] = '{255, 99, 255, 99};
  int cpre [4] = '{1, 1, 4, 1};
  int csat [4] = '{0, 0, 0, 1};

  int mcnt [4];
  int mpre [4];
  int mw   [4];
  int ms   [4];

  always #5 clk = ~clk;

  sv_param_counter u0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tcv[0]), .wrap(wr[0]), .sat(st[0])
  );

  sv_param_counter #(.MAX_VAL(99)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tcv[1]), .wrap(wr[1]), .sat(st[1])
  );

  sv_param_counter #(.PRESCALE(4)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tcv[2]), .wrap(wr[2]), .sat(st[2])
  );

  sv_param_counter #(.MAX_VAL(99), .SATURATE(1'b1)) u3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(cnt[3]), .tc(tcv[3]), .wrap(wr[3]), .sat(st[3])
  );

  // model: count taken modulo (max+1), prescale as enabled-cycle phase
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mcnt[i] = 0; mpre[i] = 0; mw[i] = 0; ms[i] = 0;
      end else begin
        mw[i] = 0; ms[i] = 0;
        if (clear) begin
          mcnt[i] = 0; mpre[i] = 0;
        end else if (load) begin
          mcnt[i] = (int'(load_val) > cmax[i]) ? cmax[i] : int'(load_val);
          mpre[i] = 0;
        end else if (en) begin
          mpre[i] = (mpre[i] + 1) % cpre[i];
          if (mpre[i] == 0) begin
            if (up_dn && mcnt[i] == cmax[i] && csat[i] == 1) ms[i] = 1;
            else if (!up_dn && mcnt[i] == 0 && csat[i] == 1) ms[i] = 1;
            else if (up_dn) begin
              mw[i] = (mcnt[i] == cmax[i]) ? 1 : 0;
              mcnt[i] = (mcnt[i] + 1) % (cmax[i] + 1);
            end else begin
              mw[i] = (mcnt[i] == 0) ? 1 : 0;
              mcnt[i] = (mcnt[i] + cmax[i]) % (cmax[i] + 1);
            end
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int i,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[u%0d] t=%0t got=%0d want=%0d",
               nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int mtc;
      mtc = ((up_dn && mcnt[i] == cmax[i]) ||
             (!up_dn && mcnt[i] == 0)) ? 1 : 0;
      cmp("count", i, int'(cnt[i]), mcnt[i]);
      cmp("tc", i, int'(tcv[i]), mtc);
      cmp("wrap", i, int'(wr[i]), mw[i]);
      cmp("sat", i, int'(st[i]), ms[i]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1;
    clear = 1'b0; load = 1'b0; load_val = 8'd0;
    #12 rst = 1'b0;

    // async reset mid-cycle
    load = 1'b1; load_val = 8'd37;
    cyc();
    chk("load37", int'(cnt[0]), 37);
    load = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cnt", int'(cnt[0]), 0);
    chk("rst_wrap", int'(wr[0]), 0);
    chk("rst_sat", int'(st[3]), 0);
    #2 rst = 1'b0;
    cyc();

    // full up run and wrap
    en = 1'b1; up_dn = 1'b1;
    repeat (255) cyc();
    chk("up255", int'(cnt[0]), 255);
    chk("tc255", int'(tcv[0]), 1);
    cyc();
    chk("wrap_cnt", int'(cnt[0]), 0);
    chk("wrap_pulse", int'(wr[0]), 1);
    cyc();
    chk("wrap_end", int'(wr[0]), 0);

    // down from 0
    en = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0; up_dn = 1'b0; en = 1'b1;
    cyc();
    chk("dn255", int'(cnt[0]), 255);
    chk("dn_wrap", int'(wr[0]), 1);
    cyc();
    chk("dn254", int'(cnt[0]), 254);
    cyc();
    chk("dn253", int'(cnt[0]), 253);

    // load clamp, clear over load
    load = 1'b1; load_val = 8'd150;
    cyc();
    chk("clamp99", int'(cnt[1]), 99);
    chk("load150", int'(cnt[0]), 150);
    clear = 1'b1;
    cyc();
    chk("clr_load", int'(cnt[1]), 0);
    clear = 1'b0; load = 1'b0; en = 1'b0;

    // prescale by 4
    up_dn = 1'b1; en = 1'b1;
    repeat (8) cyc();
    chk("pre8", int'(cnt[2]), 2);
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    cyc();
    chk("pre_frozen", int'(cnt[2]), 2);
    repeat (2) cyc();
    chk("pre_hold", int'(cnt[2]), 2);
    cyc();
    chk("pre_tick", int'(cnt[2]), 3);

    // saturate at 99
    en = 1'b0; load = 1'b1; load_val = 8'd99;
    cyc();
    load = 1'b0;
    chk("sat_ld", int'(cnt[3]), 99);
    chk("sat_tc", int'(tcv[3]), 1);
    en = 1'b1;
    cyc();
    chk("sat_hold", int'(cnt[3]), 99);
    chk("sat_p1", int'(st[3]), 1);
    chk("sat_nowrap", int'(wr[3]), 0);
    cyc();
    chk("sat_p2", int'(st[3]), 1);
    up_dn = 1'b0;
    cyc();
    chk("sat_dn98", int'(cnt[3]), 98);
    chk("sat_off", int'(st[3]), 0);

    en = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
